// File: rtl/key_debounce_sel.sv
// Multi-channel active-low key front end: 2-FF sync, debounce, press/release pulses
// and a wrapping core-select index. Define KEY_AUTOREPEAT_EN to build hold-to-repeat.
module key_debounce_sel #(
  parameter int KEYS         = 2,
  parameter int DURATION     = 50_000_000,
  parameter int NUM_CPUS     = 4,
  parameter int SEL_W        = 2,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEYS-1:0]  key_n,
  output logic [KEYS-1:0]  key_state,
  output logic [KEYS-1:0]  key_press,
  output logic [KEYS-1:0]  key_release,
  output logic [SEL_W-1:0] cpu_sel,
  output logic             cpu_sel_chg
);

  localparam int               CNT_W    = $clog2(DURATION + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DURATION);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CPUS - 1);

  // Out-of-range repeat timing leaves this marker scope in the elaborated hierarchy.
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_cfg_invalid
  end

  logic [KEYS-1:0]  sync1_q, sync2_q;
  logic [KEYS-1:0]  pressed;
  logic [CNT_W-1:0] cnt_q [KEYS];
  logic [CNT_W-1:0] cnt_d [KEYS];
  logic [KEYS-1:0]  state_q, state_d;
  logic [KEYS-1:0]  rise, fall;
  logic [KEYS-1:0]  press_q, press_d;
  logic [KEYS-1:0]  release_q, release_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             step_q, step_d;
  logic             chg_q, chg_d;

  // A change is accepted on the cycle after the counter has already seen DURATION
  // consecutive disagreeing samples, giving DURATION+2 edges of latency from the pin.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pressed = ~sync2_q;
    state_d = state_q;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < KEYS; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          state_d[i] = pressed[i];
          rise[i]    = pressed[i];
          fall[i]    = ~pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign release_d = fall;

`ifdef KEY_AUTOREPEAT_EN
  localparam int                HOLD_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int                HOLD_W     = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

  logic [HOLD_W-1:0] hold_q [KEYS];
  logic [HOLD_W-1:0] hold_d [KEYS];
  logic [KEYS-1:0]   rep_q, rep_d, rep_fire;

  // rep_q selects the long first interval or the short steady-state interval.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = '0;
    for (int i = 0; i < KEYS; i++) begin
      hold_d[i] = '0;
      if (rise[i] || fall[i] || !state_q[i]) begin
        rep_d[i] = 1'b0;
      end else if (hold_q[i] == (rep_q[i] ? RATE_LAST : DELAY_LAST)) begin
        rep_fire[i] = 1'b1;
        rep_d[i]    = 1'b1;
      end else begin
        hold_d[i] = hold_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= '0;
      for (int i = 0; i < KEYS; i++) hold_q[i] <= '0;
    end else begin
      rep_q  <= rep_d;
      hold_q <= hold_d;
    end
  end

  assign press_d = rise | rep_fire;
`else
  assign press_d = rise;
`endif

  // Key 0 steps up, key 1 steps down; a simultaneous pair cancels.
  always_comb begin
    sel_d  = sel_q;
    step_d = 1'b0;
    chg_d  = step_q;
    if (NUM_CPUS > 1) begin
      if (press_q[0] && !press_q[1]) begin
        sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        step_d = 1'b1;
      end else if (press_q[1] && !press_q[0]) begin
        sel_d  = (sel_q == '0) ? SEL_LAST : sel_q - 1'b1;
        step_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      sel_q     <= '0;
      step_q    <= 1'b0;
      chg_q     <= 1'b0;
      // NOTE: the counter array is plain flops rather than RAM, so each entry is reset.
      for (int i = 0; i < KEYS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      sel_q     <= sel_d;
      step_q    <= step_d;
      chg_q     <= chg_d;
      cnt_q     <= cnt_d;
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign cpu_sel     = sel_q;
  assign cpu_sel_chg = chg_q;

endmodule

// File: tb/tb_key_debounce_sel.sv
// Scoreboard bench for key_debounce_sel: a sliding-window reference model predicts
// each output event; a negedge monitor pops and compares. Honours KEY_AUTOREPEAT_EN.
module tb_key_debounce_sel;

  localparam int K  = 2;
  localparam int D  = 8;
  localparam int NC = 3;
  localparam int RD = 20;
  localparam int RR = 6;

  logic         clk;
  logic         rst;
  logic [K-1:0] key_n;
  logic [K-1:0] key_state, key_press, key_release;
  logic [1:0]   cpu_sel;
  logic         cpu_sel_chg;

  key_debounce_sel #(
    .KEYS(K), .DURATION(D), .NUM_CPUS(NC), .SEL_W(2),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .cpu_sel(cpu_sel), .cpu_sel_chg(cpu_sel_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [K-1:0] press;
    logic [K-1:0] rel;
    logic         chg;
  } exp_t;

  exp_t         exp_q[$];
  logic [K-1:0] hist[$];
  logic [K-1:0] m_state;
  int           sel_cur;
  int           sel_sched[int];
  bit           chg_sched[int];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  int           press_cnt0 = 0;
`ifdef KEY_AUTOREPEAT_EN
  int           next_rep[K];
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a level change is accepted when the D+1 pin samples taken
  // 2..D+2 edges ago all disagree with the debounced level.
  always @(posedge clk or posedge rst) begin : model
    logic [K-1:0] pr, rl;
    exp_t         e;
    bit           all_new;
    int           nxt;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < D + 3; k++) hist.push_back('0);
      m_state = '0;
      sel_cur = 0;
      sel_sched.delete();
      chg_sched.delete();
      exp_q.delete();
    end else begin
      cyc++;
      pr = '0;
      rl = '0;
      hist.push_front(~key_n);
      void'(hist.pop_back());
      for (int i = 0; i < K; i++) begin
        all_new = 1'b1;
        for (int j = 2; j <= D + 2; j++)
          if (hist[j][i] == m_state[i]) all_new = 1'b0;
        if (all_new) begin
          m_state[i] = ~m_state[i];
          if (m_state[i]) begin
            pr[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            next_rep[i] = cyc + RD;
`endif
          end else begin
            rl[i] = 1'b1;
          end
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (m_state[i] && cyc == next_rep[i]) begin
          pr[i] = 1'b1;
          next_rep[i] = cyc + RR;
        end
`endif
      end
      if (sel_sched.exists(cyc)) begin
        sel_cur = sel_sched[cyc];
        sel_sched.delete(cyc);
      end
      if (pr[0] ^ pr[1]) begin
        nxt = pr[0] ? (sel_cur + 1) % NC : (sel_cur + NC - 1) % NC;
        sel_sched[cyc + 1] = nxt;
        chg_sched[cyc + 2] = 1'b1;
      end
      e.cyc   = cyc;
      e.press = pr;
      e.rel   = rl;
      e.chg   = chg_sched.exists(cyc);
      if (e.chg) chg_sched.delete(cyc);
      if (pr != '0 || rl != '0 || e.chg) exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (key_press[0]) press_cnt0++;
      check("key_state", int'(key_state), int'(m_state));
      check("cpu_sel", int'(cpu_sel), sel_cur);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("sb_press", int'(key_press), int'(e.press));
        check("sb_release", int'(key_release), int'(e.rel));
        check("sb_chg", int'(cpu_sel_chg), int'(e.chg));
      end else if (key_press != '0 || key_release != '0 || cpu_sel_chg) begin
        check("sb_unexpected_pulse", int'({key_press, key_release, cpu_sel_chg}), 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  task automatic press_key(input int ch);
    key_n[ch] = 1'b0;
    step(14);
    key_n[ch] = 1'b1;
    step(14);
  endtask

  int base;

  initial begin
    rst   = 1'b1;
    key_n = '1;
    step(3);
    rst = 1'b0;
    step(2);
    check("reset_key_state", int'(key_state), 0);
    check("reset_key_press", int'(key_press), 0);
    check("reset_key_release", int'(key_release), 0);
    check("reset_cpu_sel", int'(cpu_sel), 0);
    check("reset_cpu_sel_chg", int'(cpu_sel_chg), 0);

    // Clean press: first low sample at edge 0, accepted at edge 10.
    key_n[0] = 1'b0;
    step(10);
    check("clean_before_latency", int'(key_press[0]), 0);
    step(1);
    check("clean_press", int'(key_press[0]), 1);
    check("clean_state", int'(key_state[0]), 1);
    step(1);
    check("clean_pulse_width", int'(key_press[0]), 0);
    check("clean_sel", int'(cpu_sel), 1);
    check("clean_chg_early", int'(cpu_sel_chg), 0);
    step(1);
    check("clean_chg", int'(cpu_sel_chg), 1);
    step(1);
    check("clean_chg_width", int'(cpu_sel_chg), 0);
    key_n[0] = 1'b1;
    step(16);

    // Bounce: 5 low, 1 high, then held low; last run starts at edge 6.
    base = press_cnt0;
    key_n[0] = 1'b0;
    step(5);
    key_n[0] = 1'b1;
    step(1);
    key_n[0] = 1'b0;
    step(10);
    check("bounce_before_latency", int'(key_press[0]), 0);
    step(1);
    check("bounce_press", int'(key_press[0]), 1);
    step(10);
    check("bounce_single_pulse", press_cnt0 - base, 1);
    key_n[0] = 1'b1;
    step(16);

    // Glitch shorter than the debounce window.
    base = press_cnt0;
    key_n[0] = 1'b0;
    step(7);
    key_n[0] = 1'b1;
    step(20);
    check("glitch_no_press", press_cnt0 - base, 0);

    // Wrap in both directions.
    reset_dut();
    press_key(0);
    check("wrap_sel_1", int'(cpu_sel), 1);
    press_key(0);
    check("wrap_sel_2", int'(cpu_sel), 2);
    press_key(0);
    check("wrap_sel_0", int'(cpu_sel), 0);
    press_key(1);
    check("wrap_down_sel_2", int'(cpu_sel), 2);

    // Simultaneous press cancels the select step.
    key_n = '0;
    step(11);
    check("simul_press", int'(key_press), 3);
    step(1);
    check("simul_sel_hold", int'(cpu_sel), 2);
    check("simul_no_chg_a", int'(cpu_sel_chg), 0);
    step(1);
    check("simul_no_chg_b", int'(cpu_sel_chg), 0);
    key_n = '1;
    step(10);
    check("simul_release_early", int'(key_release), 0);
    step(1);
    check("simul_release", int'(key_release), 3);
    step(1);
    check("simul_release_width", int'(key_release), 0);
    step(4);

    // Asynchronous reset mid-count with the key held.
    key_n[0] = 1'b0;
    step(7);
    #1 rst = 1'b1;
    #1;
    check("rst_async_sel", int'(cpu_sel), 0);
    check("rst_async_state", int'(key_state), 0);
    check("rst_async_press", int'(key_press), 0);
    check("rst_async_chg", int'(cpu_sel_chg), 0);
    step(2);
    rst = 1'b0;
    step(10);
    check("rst_held_before", int'(key_state[0]), 0);
    step(1);
    check("rst_held_press", int'(key_press[0]), 1);
    step(1);
    check("rst_held_sel", int'(cpu_sel), 1);
    key_n[0] = 1'b1;
    step(16);

    // Long hold: 40 cycles after acceptance.
    reset_dut();
    base = press_cnt0;
    key_n[0] = 1'b0;
    step(11);
    step(40);
`ifdef KEY_AUTOREPEAT_EN
    check("hold_press_count", press_cnt0 - base, 5);
    check("hold_sel", int'(cpu_sel), 2);
`else
    check("hold_press_count", press_cnt0 - base, 1);
    check("hold_sel", int'(cpu_sel), 1);
`endif
    key_n[0] = 1'b1;
    step(16);

    // Random traffic on both channels against the scoreboard.
    for (int n = 0; n < 150; n++) begin
      key_n = K'($urandom_range(0, 3));
      step($urandom_range(1, 16));
    end
    key_n = '1;
    step(30);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
